// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Write-side front end for the 32x32 register file. Two write sources share the
// file's single write port:
//   - the in-order pipeline writeback (WB), which always wins and passes through
//     combinationally with zero latency;
//   - an auxiliary handshaked source (multi-cycle mult/div, load-miss return),
//     buffered in a small FIFO and drained only on cycles where WB is idle.
// Per-register "write pending" status (busy1/busy2) lets decode stall reads of
// registers that still have a queued aux write. When the FIFO head has been
// blocked by WB for STARVE_LIMIT consecutive cycles, aux_stall_req asks the
// pipeline for a WB bubble so the head can drain.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   wb_RegWrite/_Write_register/_Write_data   pipeline writeback request
//   aux_valid/aux_ready/aux_reg/aux_data      aux write handshake (valid&ready)
//   query_reg1/query_reg2           registers being read by decode
//   busy1/busy2                     queried register has a write in the FIFO
//   aux_stall_req                   request a WB bubble next cycle (registered)
//   RegWrite/Write_register/Write_data        register file write port
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_Write_register,
    input  logic [31:0] wb_Write_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_reg,
    input  logic [31:0] aux_data,
    input  logic [4:0]  query_reg1,
    input  logic [4:0]  query_reg2,
    output logic        busy1,
    output logic        busy2,
    output logic        aux_stall_req,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [3:0]       LIMIT    = 4'(STARVE_LIMIT);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [3:0]       starve_cnt;
    logic [3:0]       starve_nxt;

    // Entry payload carries no reset: validity is defined by rd_ptr/count.
    logic [4:0]       fifo_reg  [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] entry_vld;

    logic wb_act;
    logic fifo_empty;
    logic push;
    logic pop;

    // Writes to r0 are architecturally dropped, so a WB to r0 does not occupy
    // the port and an aux push to r0 completes its handshake without queueing.
    assign wb_act     = wb_RegWrite && (wb_Write_register != 5'd0);
    assign fifo_empty = (count == '0);
    assign aux_ready  = (count != FULL_CNT);
    assign push       = aux_valid && aux_ready && (aux_reg != 5'd0);
    assign pop        = !wb_act && !fifo_empty;

    // Write port mux: WB first, FIFO head second, otherwise idle.
    always_comb begin
        RegWrite       = 1'b0;
        Write_register = 5'd0;
        Write_data     = 32'd0;
        if (wb_act) begin
            RegWrite       = 1'b1;
            Write_register = wb_Write_register;
            Write_data     = wb_Write_data;
        end else if (!fifo_empty) begin
            RegWrite       = 1'b1;
            Write_register = fifo_reg[rd_ptr];
            Write_data     = fifo_data[rd_ptr];
        end
    end

    // An entry is live when its distance from the head (modulo DEPTH) is
    // below the occupancy count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs      = '0;
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, offs} < count);
        end
    end

    // Busy scan covers every live entry, including the head being popped now.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (fifo_reg[i] == query_reg1)) busy1 = 1'b1;
            if (entry_vld[i] && (fifo_reg[i] == query_reg2)) busy2 = 1'b1;
        end
        if (query_reg1 == 5'd0) busy1 = 1'b0;
        if (query_reg2 == 5'd0) busy2 = 1'b0;
    end

    // Starvation: count cycles where a queued head loses to WB; saturate.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || fifo_empty) begin
            starve_nxt = 4'd0;
        end else if (wb_act && (starve_cnt != LIMIT)) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    // ---- control state register boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            starve_cnt    <= 4'd0;
            aux_stall_req <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            starve_cnt    <= starve_nxt;
            aux_stall_req <= (starve_nxt == LIMIT);
        end
    end

    // ---- FIFO payload storage boundary ----
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= aux_reg;
            fifo_data[wr_ptr] <= aux_data;
        end
    end

endmodule
